// File: rtl/secded_mem_engine.sv
// Memory-side Hamming SECDED coprocessor: walks N_MSG 16-bit words in byte memory,
// encoding 11-bit messages or decoding/correcting codewords, with SEC/DED counters.
module secded_mem_engine #(
    parameter int AW    = 8,
    parameter int N_MSG = 15,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          mode,
    input  logic [AW-1:0] base_in,
    input  logic [AW-1:0] base_out,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic [CW-1:0] sec_cnt,
    output logic [CW-1:0] ded_cnt
);

    // Handshake: req is accepted only when not busy (IDLE/DONE); acceptance latches mode and
    // bases, clears ack and counters, and busy stays high until ack rises on DONE entry.
    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_MSG - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] base_in_q, base_in_d;
    logic [AW-1:0] base_out_q, base_out_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    lo_q, lo_d;
    logic [15:0]   res_q, res_d;
    logic [CW-1:0] sec_cnt_q, sec_cnt_d;
    logic [CW-1:0] ded_cnt_q, ded_cnt_d;

    logic [10:0]   d_enc;
    logic [15:0]   enc_body, enc_hp, enc_word;
    logic          p1, p2, p4, p8;
    logic [15:0]   src_word, fixed_word, dec_word;
    logic [3:0]    syn;
    logic          par;
    logic [1:0]    status;
    logic [AW-1:0] in_addr, out_addr;

    // Masks 0xAAAA/0xCCCC/0xF0F0/0xFF00 select positions whose index has bit 0/1/2/3 set.
    always_comb begin
        d_enc    = {mem_rd_data[2:0], lo_q};
        enc_body = {d_enc[10:4], 1'b0, d_enc[3:1], 1'b0, d_enc[0], 3'b000};
        p1       = ^(enc_body & 16'hAAAA);
        p2       = ^(enc_body & 16'hCCCC);
        p4       = ^(enc_body & 16'hF0F0);
        p8       = ^(enc_body & 16'hFF00);
        enc_hp   = enc_body | {7'b0, p8, 3'b0, p4, 1'b0, p2, p1, 1'b0};
        enc_word = {enc_hp[15:1], ^enc_hp[15:1]};

        src_word   = {mem_rd_data, lo_q};
        syn        = {^(src_word & 16'hFF00), ^(src_word & 16'hF0F0),
                      ^(src_word & 16'hCCCC), ^(src_word & 16'hAAAA)};
        par        = ^src_word;
        fixed_word = src_word ^ (par ? (16'd1 << syn) : 16'd0);
        status     = par ? 2'b01 : ((syn != 4'd0) ? 2'b10 : 2'b00);
        dec_word   = {status, 3'b000, fixed_word[15:9], fixed_word[7:5], fixed_word[3]};
    end

    assign in_addr  = base_in_q + {idx_q[AW-2:0], 1'b0};
    assign out_addr = base_out_q + {idx_q[AW-2:0], 1'b0};

    always_comb begin
        state_d     = state_q;
        go_d        = go_q;
        mode_d      = mode_q;
        base_in_d   = base_in_q;
        base_out_d  = base_out_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        res_d       = res_q;
        sec_cnt_d   = sec_cnt_q;
        ded_cnt_d   = ded_cnt_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_q) begin
                    go_d    = 1'b0;
                    idx_d   = '0;
                    state_d = S_RD_LO;
                end else if (req) begin
                    // One setup cycle in IDLE before the first read gives the 1 + 5*N latency.
                    go_d       = 1'b1;
                    mode_d     = mode;
                    base_in_d  = base_in;
                    base_out_d = base_out;
                    sec_cnt_d  = '0;
                    ded_cnt_d  = '0;
                    state_d    = S_IDLE;
                end
            end
            S_RD_LO: begin
                mem_addr = in_addr;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr = in_addr + AW'(1);
                lo_d     = mem_rd_data;
                state_d  = S_CAP;
            end
            S_CAP: begin
                res_d = mode_q ? dec_word : enc_word;
                if (mode_q && status == 2'b01 && sec_cnt_q != CNT_MAX) begin
                    sec_cnt_d = sec_cnt_q + CW'(1);
                end
                if (mode_q && status == 2'b10 && ded_cnt_q != CNT_MAX) begin
                    ded_cnt_d = ded_cnt_q + CW'(1);
                end
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr    = out_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = res_q[7:0];
                state_d     = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr    = out_addr + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = res_q[15:8];
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_RD_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            go_q       <= 1'b0;
            mode_q     <= 1'b0;
            base_in_q  <= '0;
            base_out_q <= '0;
            idx_q      <= '0;
            lo_q       <= 8'h00;
            res_q      <= 16'h0000;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            mode_q     <= mode_d;
            base_in_q  <= base_in_d;
            base_out_q <= base_out_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            res_q      <= res_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign ack     = (state_q == S_DONE);
    assign busy    = go_q || (state_q != S_IDLE && state_q != S_DONE);
    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;

endmodule

// File: tb/tb_secded_mem_engine.sv
// Bench for secded_mem_engine: single-message vector table on an N_MSG=1 instance, and
// randomized 15-message runs, reset abort and busy-req handling on an N_MSG=15 instance.
module tb_secded_mem_engine;

    logic       clk, reset;
    logic       req_a, mode_a, ack_a, busy_a, wen_a;
    logic [7:0] bin_a, bout_a, addr_a, wdata_a, rdata_a, sec_a, ded_a;
    logic       req_b, mode_b, ack_b, busy_b, wen_b;
    logic [7:0] bin_b, bout_b, addr_b, wdata_b, rdata_b, sec_b, ded_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         wr_cnt_b = 0;

    secded_mem_engine #(.AW(8), .N_MSG(1), .CW(8)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .mode(mode_a), .base_in(bin_a),
        .base_out(bout_a), .ack(ack_a), .busy(busy_a), .mem_addr(addr_a),
        .mem_wr_en(wen_a), .mem_wr_data(wdata_a), .mem_rd_data(rdata_a),
        .sec_cnt(sec_a), .ded_cnt(ded_a)
    );

    secded_mem_engine #(.AW(8), .N_MSG(15), .CW(8)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .mode(mode_b), .base_in(bin_b),
        .base_out(bout_b), .ack(ack_b), .busy(busy_b), .mem_addr(addr_b),
        .mem_wr_en(wen_b), .mem_wr_data(wdata_b), .mem_rd_data(rdata_b),
        .sec_cnt(sec_b), .ded_cnt(ded_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read byte memories
    always @(posedge clk) begin
        if (wen_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a];
        if (wen_b) begin
            mem_b[addr_b] <= wdata_b;
            wr_cnt_b = wr_cnt_b + 1;
        end
        rdata_b <= mem_b[addr_b];
    end

    typedef struct {
        logic        mode;
        logic [7:0]  bin;
        logic [7:0]  bout;
        logic [15:0] src;
        logic [15:0] exp;
        logic [7:0]  esec;
        logic [7:0]  eded;
    } vec_t;

    vec_t        vecs [12];
    logic [10:0] dv [15];
    logic [15:0] ev [15];
    logic [15:0] wv [15];
    int          lat, n, wc, esec_sum, eded_sum;
    logic        a1, b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_encode(input logic [10:0] d);
        logic [15:0] w;
        logic        x;
        int          j;
        w = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                w[k] = d[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) x = x ^ w[k];
            w[p] = x;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Returns {ded, sec, output word}
    function automatic logic [17:0] model_decode(input logic [15:0] cw);
        logic [15:0] w;
        logic [10:0] d;
        logic [1:0]  st;
        int          syn, j;
        w   = cw;
        syn = 0;
        for (int k = 1; k < 16; k++) if (w[k]) syn = syn ^ k;
        if (^w) begin
            w[syn] = ~w[syn];
            st = 2'b01;
        end else if (syn != 0) begin
            st = 2'b10;
        end else begin
            st = 2'b00;
        end
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[j] = w[k];
                j++;
            end
        end
        return {st == 2'b10, st == 2'b01, st, 3'b000, d};
    endfunction

    task automatic put_a(input logic [7:0] a, input logic [15:0] w);
        mem_a[a]        = w[7:0];
        mem_a[a + 8'd1] = w[15:8];
    endtask

    task automatic put_b(input logic [7:0] a, input logic [15:0] w);
        mem_b[a]        = w[7:0];
        mem_b[a + 8'd1] = w[15:8];
    endtask

    function automatic logic [15:0] get_a(input logic [7:0] a);
        return {mem_a[a + 8'd1], mem_a[a]};
    endfunction

    function automatic logic [15:0] get_b(input logic [7:0] a);
        return {mem_b[a + 8'd1], mem_b[a]};
    endfunction

    task automatic run_a(input logic m, input logic [7:0] bi, input logic [7:0] bo,
                         output int lt);
        @(negedge clk);
        req_a = 1'b1; mode_a = m; bin_a = bi; bout_a = bo;
        @(negedge clk);
        req_a = 1'b0; mode_a = ~m; bin_a = 8'($urandom); bout_a = 8'($urandom);
        lt = 0;
        while (ack_a !== 1'b1 && lt < 200) begin
            @(negedge clk);
            lt++;
        end
    endtask

    task automatic run_b(input logic m, input logic [7:0] bi, input logic [7:0] bo,
                         input logic glitch, output int lt, output logic ack1,
                         output logic busy1);
        @(negedge clk);
        req_b = 1'b1; mode_b = m; bin_b = bi; bout_b = bo;
        @(negedge clk);
        req_b = 1'b0; mode_b = ~m; bin_b = 8'($urandom); bout_b = 8'($urandom);
        ack1 = ack_b;
        busy1 = busy_b;
        lt = 0;
        while (ack_b !== 1'b1 && lt < 1000) begin
            req_b = glitch && (lt == 10);
            @(negedge clk);
            lt++;
        end
        req_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_a = 0; mode_a = 0; bin_a = 0; bout_a = 0;
        req_b = 0; mode_b = 0; bin_b = 0; bout_b = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end

        vecs[0]  = '{1'b0, 8'h10, 8'h80, 16'h07FF, 16'hFFFF, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 8'h12, 8'h82, 16'h0001, 16'h000F, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 8'h14, 8'h84, 16'h0000, 16'h0000, 8'd0, 8'd0};
        vecs[3]  = '{1'b0, 8'hFF, 8'h86, 16'hF801, 16'h000F, 8'd0, 8'd0};
        vecs[4]  = '{1'b0, 8'h16, 8'hFF, 16'h07FF, 16'hFFFF, 8'd0, 8'd0};
        vecs[5]  = '{1'b1, 8'h20, 8'h90, 16'hFFDF, 16'h47FF, 8'd1, 8'd0};
        vecs[6]  = '{1'b1, 8'h22, 8'h92, 16'hFFFE, 16'h47FF, 8'd1, 8'd0};
        vecs[7]  = '{1'b1, 8'h24, 8'h94, 16'hFFDD, 16'h87FD, 8'd0, 8'd1};
        vecs[8]  = '{1'b1, 8'h26, 8'h96, 16'hFFFF, 16'h07FF, 8'd0, 8'd0};
        vecs[9]  = '{1'b1, 8'h28, 8'h98, 16'h000F, 16'h0001, 8'd0, 8'd0};
        vecs[10] = '{1'b1, 8'h2A, 8'h9A, 16'h0000, 16'h0000, 8'd0, 8'd0};
        vecs[11] = '{1'b1, 8'h2C, 8'h9C, 16'h0007, 16'h4001, 8'd1, 8'd0};

        repeat (3) @(negedge clk);
        check("rst_ack_a", ack_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_wen_a", wen_a, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_wdata_a", wdata_a, 0);
        check("rst_cnt_a", {sec_a, ded_a}, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_busy_b", busy_b, 0);
        req_a = 1'b1;
        @(negedge clk);
        check("rst_over_req_busy", busy_a, 0);
        req_a = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            put_a(vecs[i].bout, 16'hDEAD);
            put_a(vecs[i].bin, vecs[i].src);
            run_a(vecs[i].mode, vecs[i].bin, vecs[i].bout, lat);
            check($sformatf("vec%0d_latency", i), lat, 6);
            check($sformatf("vec%0d_word", i), get_a(vecs[i].bout), vecs[i].exp);
            check($sformatf("vec%0d_sec", i), sec_a, vecs[i].esec);
            check($sformatf("vec%0d_ded", i), ded_a, vecs[i].eded);
            check($sformatf("vec%0d_busy", i), busy_a, 0);
        end

        // 15 random encodes, junk in hi[7:3]
        for (int i = 0; i < 15; i++) begin
            dv[i] = 11'($urandom);
            put_b(8'(2 * i), {5'($urandom_range(0, 31)), dv[i]});
        end
        wc = wr_cnt_b;
        run_b(1'b0, 8'h00, 8'h40, 1'b0, lat, a1, b1);
        check("enc15_latency", lat, 76);
        check("enc15_busy_after_req", b1, 1);
        check("enc15_write_count", wr_cnt_b - wc, 30);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("enc15_word%0d", i), get_b(8'(8'h40 + 2 * i)), model_encode(dv[i]));
        end
        check("enc15_cnts", {sec_b, ded_b}, 0);

        // one random flip per word, output region wraps past 0xFF
        for (int i = 0; i < 15; i++) begin
            put_b(8'(8'h40 + 2 * i), model_encode(dv[i]) ^ (16'd1 << $urandom_range(0, 15)));
        end
        run_b(1'b1, 8'h40, 8'hF0, 1'b0, lat, a1, b1);
        check("dec15_ack_clear", a1, 0);
        check("dec15_busy", b1, 1);
        check("dec15_latency", lat, 76);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("dec15_word%0d", i), get_b(8'(8'hF0 + 2 * i)),
                  {2'b01, 3'b000, dv[i]});
        end
        check("dec15_sec", sec_b, 15);
        check("dec15_ded", ded_b, 0);

        // random mix of 0, 1 and 2 flips
        esec_sum = 0;
        eded_sum = 0;
        for (int i = 0; i < 15; i++) begin
            int f1, f2, nf;
            logic [17:0] r;
            wv[i] = model_encode(11'($urandom));
            nf = $urandom_range(0, 2);
            f1 = $urandom_range(0, 15);
            f2 = (f1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) wv[i][f1] = ~wv[i][f1];
            if (nf == 2) wv[i][f2] = ~wv[i][f2];
            r = model_decode(wv[i]);
            ev[i] = r[15:0];
            esec_sum += int'(r[16]);
            eded_sum += int'(r[17]);
            put_b(8'(8'h80 + 2 * i), wv[i]);
        end
        run_b(1'b1, 8'h80, 8'hC0, 1'b0, lat, a1, b1);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("mix_word%0d", i), get_b(8'(8'hC0 + 2 * i)), ev[i]);
        end
        check("mix_sec", sec_b, esec_sum);
        check("mix_ded", ded_b, eded_sum);

        // abort with reset during WR_LO of message 3 (writes to 0xF6)
        @(negedge clk);
        req_b = 1'b1; mode_b = 1'b1; bin_b = 8'h40; bout_b = 8'hF0;
        @(negedge clk);
        req_b = 1'b0;
        n = 0;
        while (!(wen_b === 1'b1 && addr_b === 8'hF6) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_found_wr_lo3", n < 200, 1);
        reset = 1'b1;
        @(negedge clk);
        wc = wr_cnt_b;
        check("abort_wen", wen_b, 0);
        check("abort_ack", ack_b, 0);
        check("abort_busy", busy_b, 0);
        check("abort_cnts", {sec_b, ded_b}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_writes", wr_cnt_b - wc, 0);
        check("abort_idle_busy", busy_b, 0);

        // full rerun; a req mid-run must be ignored
        for (int i = 0; i < 15; i++) begin
            dv[i] = 11'($urandom);
            put_b(8'(2 * i), {5'b0, dv[i]});
        end
        run_b(1'b0, 8'h00, 8'h60, 1'b1, lat, a1, b1);
        check("rerun_latency", lat, 76);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("rerun_word%0d", i), get_b(8'(8'h60 + 2 * i)), model_encode(dv[i]));
        end
        check("rerun_cnts", {sec_b, ded_b}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
